// File: rtl/player_motion_controller_4dir_pkg.sv
// rtl/player_motion_controller_4dir_pkg.sv - shared encodings for the player motion block
package player_motion_pkg;

    localparam int FRAC_BITS_DEF = 4;

    localparam logic [2:0] GDIR_NONE  = 3'd0;
    localparam logic [2:0] GDIR_UP    = 3'd1;
    localparam logic [2:0] GDIR_RIGHT = 3'd2;
    localparam logic [2:0] GDIR_DOWN  = 3'd3;
    localparam logic [2:0] GDIR_LEFT  = 3'd4;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_GROUNDED = 2'd1,
        ST_RISING   = 2'd2,
        ST_FALLING  = 2'd3
    } motion_state_e;

endpackage

// File: rtl/player_motion_controller_4dir_if.sv
// rtl/player_motion_controller_4dir_if.sv - switch/arena inputs and position outputs of the motion block
interface player_motion_controller_4dir_if #(
    parameter int POS_W = 10
);
    logic             switch_up;
    logic             switch_down;
    logic             switch_left;
    logic             switch_right;
    logic [2:0]       gravity_direction;
    logic [POS_W-1:0] game_display_x0;
    logic [POS_W-1:0] game_display_y0;
    logic [POS_W-1:0] game_display_x1;
    logic [POS_W-1:0] game_display_y1;
    logic [POS_W-1:0] collider_ground_pos;
    logic             collider_ground_valid;
    logic [POS_W-1:0] player_pos_x;
    logic [POS_W-1:0] player_pos_y;
    logic [POS_W-1:0] player_w;
    logic [POS_W-1:0] player_h;
    logic             on_ground;
    logic [1:0]       motion_state;

    modport master (
        output switch_up, switch_down, switch_left, switch_right, gravity_direction,
               game_display_x0, game_display_y0, game_display_x1, game_display_y1,
               collider_ground_pos, collider_ground_valid,
        input  player_pos_x, player_pos_y, player_w, player_h, on_ground, motion_state
    );

    modport slave (
        input  switch_up, switch_down, switch_left, switch_right, gravity_direction,
               game_display_x0, game_display_y0, game_display_x1, game_display_y1,
               collider_ground_pos, collider_ground_valid,
        output player_pos_x, player_pos_y, player_w, player_h, on_ground, motion_state
    );
endinterface

// File: rtl/player_motion_controller_4dir_axis_step.sv
// rtl/player_motion_controller_4dir_axis_step.sv - one axis: add a signed delta and clamp to [lo, hi]
module player_axis_step #(
    parameter int W  = 14,
    parameter int SW = W + 2
) (
    input  logic [W-1:0]         pos,
    input  logic signed [SW-1:0] delta,
    input  logic signed [SW-1:0] lo,
    input  logic signed [SW-1:0] hi,
    output logic [W-1:0]         next,
    output logic                 hit_lo,
    output logic                 hit_hi
);
    logic signed [SW-1:0] sum;

    assign sum    = $signed({{(SW-W){1'b0}}, pos}) + delta;
    assign hit_lo = (sum <= lo);
    assign hit_hi = (sum >= hi);
    // lo wins so a box narrower than the player pins to its low edge
    assign next   = hit_lo ? W'(lo) : (hit_hi ? W'(hi) : W'(sum));
endmodule

// File: rtl/player_motion_controller_4dir.sv
// rtl/player_motion_controller_4dir.sv - fixed-point player motion under four-way gravity
module player_motion_controller_4dir
    import player_motion_pkg::*;
#(
    parameter int POS_W        = 10,
    parameter int FRAC_BITS    = FRAC_BITS_DEF,
    parameter int PLAYER_POS_X = 320,
    parameter int PLAYER_POS_Y = 240,
    parameter int PLAYER_W     = 30,
    parameter int PLAYER_H     = 30,
    parameter int MOVE_SPEED   = 18,
    parameter int JUMP_SPEED   = 24,
    parameter int GRAVITY      = 12,
    parameter int MAX_FALL     = 96,
    parameter int JUMP_H       = 80
) (
    input logic clk_player_control,
    input logic reset_n,
    player_motion_controller_4dir_if.slave bus
);
    localparam int W   = POS_W + FRAC_BITS;
    localparam int SW  = W + 2;
    localparam int FSW = FRAC_BITS + 8;
    typedef logic signed [SW-1:0] sfix_t;

    localparam sfix_t W_F  = sfix_t'(PLAYER_W * (1 << FRAC_BITS));
    localparam sfix_t H_F  = sfix_t'(PLAYER_H * (1 << FRAC_BITS));
    localparam sfix_t JH_F = sfix_t'(JUMP_H * (1 << FRAC_BITS));
    localparam sfix_t MS_F = sfix_t'(MOVE_SPEED);
    localparam sfix_t JS_F = sfix_t'(JUMP_SPEED);

    function automatic sfix_t scale(input logic [POS_W-1:0] v);
        return sfix_t'({v, {FRAC_BITS{1'b0}}});
    endfunction

    // "a is at or beyond b" measured in the direction gravity pulls
    function automatic logic at_or_past(input logic pos_dir, input sfix_t a, input sfix_t b);
        return pos_dir ? (a >= b) : (a <= b);
    endfunction

    logic [W-1:0]   pos_x, pos_y, apex, nx, ny;
    logic [FSW-1:0] fall_speed, fs_n;
    logic [FSW:0]   fs_sum;
    logic [2:0]     gdir_q, g;
    motion_state_e  state, state_n;
    logic [W-1:0]   apex_n;
    logic           vert, gpos, jump, apex_hit, landed, away, edge_hit;
    logic           x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;
    sfix_t xlo, xhi, yhi, ylo, xhi_raw, yhi_raw, gp, glo, ghi, floor_pos;
    sfix_t fs_s, apex_s, rise_cand, jump_apex, free_dx, free_dy, lat_d, g_d, l_d, dx, dy;

    assign g    = (bus.gravity_direction > GDIR_LEFT) ? GDIR_NONE : bus.gravity_direction;
    assign vert = (g == GDIR_UP) || (g == GDIR_DOWN);
    assign gpos = (g == GDIR_DOWN) || (g == GDIR_RIGHT);

    assign xlo     = scale(bus.game_display_x0);
    assign ylo     = scale(bus.game_display_y0);
    assign xhi_raw = scale(bus.game_display_x1) - W_F;
    assign yhi_raw = scale(bus.game_display_y1) - H_F;
    assign xhi     = (xhi_raw < xlo) ? xlo : xhi_raw;
    assign yhi     = (yhi_raw < ylo) ? ylo : yhi_raw;

    assign gp  = vert ? sfix_t'(pos_y) : sfix_t'(pos_x);
    assign glo = vert ? ylo : xlo;
    assign ghi = vert ? yhi : xhi;

    always_comb begin
        floor_pos = '0;
        jump      = 1'b0;
        case (g)
            GDIR_DOWN: begin
                jump      = bus.switch_up;
                floor_pos = ((bus.collider_ground_valid && bus.collider_ground_pos < bus.game_display_y1) ?
                             scale(bus.collider_ground_pos) : scale(bus.game_display_y1)) - H_F;
            end
            GDIR_UP: begin
                jump      = bus.switch_down;
                floor_pos = (bus.collider_ground_valid && bus.collider_ground_pos > bus.game_display_y0) ?
                            scale(bus.collider_ground_pos) : scale(bus.game_display_y0);
            end
            GDIR_RIGHT: begin
                jump      = bus.switch_left;
                floor_pos = ((bus.collider_ground_valid && bus.collider_ground_pos < bus.game_display_x1) ?
                             scale(bus.collider_ground_pos) : scale(bus.game_display_x1)) - W_F;
            end
            GDIR_LEFT: begin
                jump      = bus.switch_right;
                floor_pos = (bus.collider_ground_valid && bus.collider_ground_pos > bus.game_display_x0) ?
                            scale(bus.collider_ground_pos) : scale(bus.game_display_x0);
            end
            default: ;
        endcase
    end

    assign fs_s      = sfix_t'(fall_speed);
    assign apex_s    = sfix_t'(apex);
    assign rise_cand = gpos ? gp - JS_F : gp + JS_F;
    assign apex_hit  = at_or_past(gpos, apex_s, rise_cand);
    assign landed    = at_or_past(gpos, gpos ? gp + fs_s : gp - fs_s, floor_pos);
    assign away      = !at_or_past(gpos, gp, floor_pos);
    assign jump_apex = gpos ? ((gp - JH_F < glo) ? glo : gp - JH_F)
                            : ((gp + JH_F > ghi) ? ghi : gp + JH_F);
    assign free_dx   = (bus.switch_right ? MS_F : '0) - (bus.switch_left ? MS_F : '0);
    assign free_dy   = (bus.switch_down ? MS_F : '0) - (bus.switch_up ? MS_F : '0);
    assign lat_d     = vert ? free_dx : free_dy;
    assign fs_sum    = (FSW+1)'(fall_speed) + (FSW+1)'(GRAVITY);

    // g_d: motion along gravity, l_d: motion across it
    always_comb begin
        g_d = '0;
        l_d = lat_d;
        if (g == GDIR_NONE || g != gdir_q) begin
            l_d = '0;
        end else begin
            case (state)
                ST_GROUNDED: if (!jump && !away) g_d = floor_pos - gp;
                ST_RISING:   if (jump) g_d = apex_hit ? apex_s - gp : rise_cand - gp;
                ST_FALLING:  g_d = landed ? floor_pos - gp : (gpos ? fs_s : -fs_s);
                default:     l_d = '0;
            endcase
        end
        if (g == GDIR_NONE) begin
            dx = free_dx;
            dy = free_dy;
        end else begin
            dx = vert ? l_d : g_d;
            dy = vert ? g_d : l_d;
        end
    end

    player_axis_step #(.W(W), .SW(SW)) u_step_x (
        .pos(pos_x), .delta(dx), .lo(xlo), .hi(xhi), .next(nx), .hit_lo(x_hit_lo), .hit_hi(x_hit_hi)
    );
    player_axis_step #(.W(W), .SW(SW)) u_step_y (
        .pos(pos_y), .delta(dy), .lo(ylo), .hi(yhi), .next(ny), .hit_lo(y_hit_lo), .hit_hi(y_hit_hi)
    );

    // rising moves against gravity, so the edge it can hit is the low one for +gravity
    assign edge_hit = vert ? (gpos ? y_hit_lo : y_hit_hi) : (gpos ? x_hit_lo : x_hit_hi);

    always_comb begin
        state_n = state;
        fs_n    = fall_speed;
        apex_n  = apex;
        if (g == GDIR_NONE) begin
            state_n = ST_FREE;
            fs_n    = '0;
        end else if (g != gdir_q) begin
            state_n = ST_FALLING;
            fs_n    = '0;
        end else begin
            case (state)
                ST_GROUNDED: begin
                    if (jump) begin
                        state_n = ST_RISING;
                        apex_n  = W'(jump_apex);
                    end else if (away) begin
                        state_n = ST_FALLING;
                        fs_n    = '0;
                    end
                end
                ST_RISING: begin
                    if (!jump || apex_hit || edge_hit) begin
                        state_n = ST_FALLING;
                        fs_n    = '0;
                    end
                end
                ST_FALLING: begin
                    if (landed) begin
                        state_n = ST_GROUNDED;
                        fs_n    = '0;
                    end else begin
                        fs_n = (fs_sum > (FSW+1)'(MAX_FALL)) ? FSW'(MAX_FALL) : FSW'(fs_sum);
                    end
                end
                default: begin
                    state_n = ST_FALLING;
                    fs_n    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_player_control or negedge reset_n) begin
        if (!reset_n) begin
            pos_x      <= W'(PLAYER_POS_X * (1 << FRAC_BITS));
            pos_y      <= W'(PLAYER_POS_Y * (1 << FRAC_BITS));
            state      <= ST_FREE;
            fall_speed <= '0;
            apex       <= '0;
            gdir_q     <= GDIR_NONE;
        end else begin
            pos_x      <= nx;
            pos_y      <= ny;
            state      <= state_n;
            fall_speed <= fs_n;
            apex       <= apex_n;
            gdir_q     <= g;
        end
    end

    assign bus.player_pos_x = pos_x[W-1:FRAC_BITS];
    assign bus.player_pos_y = pos_y[W-1:FRAC_BITS];
    assign bus.player_w     = POS_W'(PLAYER_W);
    assign bus.player_h     = POS_W'(PLAYER_H);
    assign bus.on_ground    = (state == ST_GROUNDED);
    assign bus.motion_state = state;
endmodule

// File: doc/player_motion_controller_4dir.md
# player_motion_controller_4dir

Next-generation player motion block for the Sans-fight arena. It integrates the heart's position in fixed point under gravity pointing in any of four directions, or no gravity. It runs a grounded/rising/falling/free state machine with a per-direction jump and a per-direction ground collider, and clamps the player to the game display box. It sits between the switch debouncers and the renderer/collision blocks, clocked by the slow player-control tick.

## Interface
- POS_W, 10, integer pixel coordinate width
- FRAC_BITS, 4, fractional bits of internal position/speed
- PLAYER_POS_X, 320, reset X (pixels)
- PLAYER_POS_Y, 240, reset Y (pixels)
- PLAYER_W, 30, player width (pixels)
- PLAYER_H, 30, player height (pixels)
- MOVE_SPEED, 18, lateral/free speed, 1/2^FRAC_BITS px per tick
- JUMP_SPEED, 24, rise speed, 1/2^FRAC_BITS px per tick
- GRAVITY, 12, fall acceleration, 1/2^FRAC_BITS px per tick²
- MAX_FALL, 96, fall-speed saturation, 1/2^FRAC_BITS px per tick
- JUMP_H, 80, max jump height (pixels)

- clk_player_control  in  1  player tick clock
- reset_n  in  1  asynchronous, active-low reset
- switch_up / switch_down / switch_left / switch_right  in  1 each  debounced direction inputs
- gravity_direction  in  3  0 none, 1 up, 2 right, 3 down, 4 left; 5–7 treated as 0
- game_display_x0, _y0, _x1, _y1  in  POS_W each  arena box (pixels, inclusive edges)
- collider_ground_pos  in  POS_W  surface coordinate along the gravity axis
- collider_ground_valid  in  1  collider_ground_pos is active
- player_pos_x, player_pos_y  out  POS_W  integer part of internal position (top-left)
- player_w, player_h  out  POS_W  constant PLAYER_W / PLAYER_H
- on_ground  out  1  state == GROUNDED
- motion_state  out  2  FREE=0, GROUNDED=1, RISING=2, FALLING=3

## Operation
- Internal pos_x/pos_y: POS_W+FRAC_BITS unsigned. fall_speed: FRAC_BITS+8 bits. apex: POS_W+FRAC_BITS. gdir_q: last gravity_direction.
- All intermediate sums are computed signed, POS_W+FRAC_BITS+2 bits wide, so they never wrap.
- Gravity frame:
  - Down: the jump key is switch_up, and lateral motion is left/right.
  - Up: the jump key is switch_down.
  - Right: the jump key is switch_left, and lateral motion is up/down.
  - Left: the jump key is switch_right.
  - The key pointing along gravity is ignored.
- Floor along the gravity axis:
  - Down: min(y1, collider) − H.
  - Up: max(y0, collider).
  - Right: min(x1, collider) − W.
  - Left: max(x0, collider).
  - The collider term is used only when valid. All values are scaled by 2^FRAC_BITS.
- Priority each tick:
  1. Gravity none → FREE.
  2. Else, gravity_direction ≠ gdir_q → FALLING with fall_speed=0.
  3. Else, normal transitions.
- FREE: each held key moves MOVE_SPEED. Opposite keys held together cancel. fall_speed=0.
- GROUNDED: position equals floor.
  - Jump key held → RISING. apex = pos − JUMP_H·2^F against gravity, clamped to the box.
  - Floor moved away from the player (walk-off, collider dropped) → FALLING.
  - Floor moved into the player → snap to floor.
- RISING: move JUMP_SPEED against gravity. Go to FALLING with fall_speed=0 when any of these happen:
  - the jump key is released,
  - apex is reached (snap to apex),
  - the box edge is hit.
- FALLING:
  - fall_speed ← min(fall_speed+GRAVITY, MAX_FALL).
  - pos advances by the old fall_speed.
  - Reaching or passing the floor → snap, GROUNDED, fall_speed=0.
- Lateral keys move MOVE_SPEED in GROUNDED, RISING and FALLING.
- Final clamp every tick to [x0, x1−W] × [y0, y1−H]. If the box is narrower than the player, pin to x0/y0.

## Timing
- Reset (async assert, sync release):
  - pos = (PLAYER_POS_X, PLAYER_POS_Y)·2^F
  - state FREE, fall_speed 0, apex 0, gdir_q 0
  - outputs 320, 240, 30, 30, on_ground 0, motion_state 0
- One update per clk_player_control edge. Outputs are taken directly from registers, with zero added latency: player_pos_* = pos[POS_W+F−1:F].
- Input changes affect the state on the next edge.
- Reset asserted mid-jump or mid-fall aborts immediately; there are no partial states.

## Structure
- Shared package player_motion_pkg:
  - gravity encodings GDIR_NONE/UP/RIGHT/DOWN/LEFT
  - state encodings
  - default FRAC_BITS
- Sub-module player_axis_step, instantiated once per axis: signed delta + lo/hi bounds → next clamped coordinate, plus a hit_lo/hit_hi flag.

## Test plan
- reset_n low mid-fall → (320,240), motion_state 0, on_ground 0 asynchronously, before the next edge.
- Box (100,100)-(540,400), gravity 3, no keys → fall_speed 12, 24, … saturating at 96. Lands at y=370, GROUNDED, fall_speed 0.
- GROUNDED at y=370, hold switch_up → rises 1.5 px/tick, stops at y=290 (apex 4640), FALLING, relands at 370.
- Gravity 2 → lands at x=510. switch_left jumps toward 430. switch_right is ignored.
- Gravity 3, collider_valid=1 pos=300 → lands at y=270. Drop valid → FALLING, lands at 370.
- Gravity 0, switch_up+switch_down held → y unchanged. switch_right held → x clamps at 510. Changing gravity 0→3 enters FALLING on the next edge.
